// File: rtl/ccsds_asm_randomizer_s.sv
// Serial CCSDS channel-access stage: prepends the ASM to every LDPC codeblock and
// XORs the codeblock bits with the CCSDS pseudo-randomizer, one bit per beat.
module ccsds_asm_randomizer_s #(
    parameter logic [31:0] ASM       = 32'h1ACFFC1D,
    parameter int          ASM_LEN   = 32,
    parameter int          BLOCK_LEN = 8160,
    parameter bit          RAND_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic s_axis_tdata,
    input  logic s_axis_tvalid,
    output logic s_axis_tready,
    input  logic s_axis_tlast,
    output logic m_axis_tdata,
    output logic m_axis_tvalid,
    output logic m_axis_tlast,
    input  logic m_axis_tready,
    output logic frame_err
);
    localparam int CNT_MAX = (BLOCK_LEN > 32) ? BLOCK_LEN : 32;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] ASM_LAST = CNT_W'(ASM_LEN - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic {ST_ASM, ST_DATA} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       lfsr, lfsr_d;
    logic             tdata_d, tvalid_d, tlast_d, ferr_d;
    logic             load, in_hs, last_bit, fb;
    logic [4:0]       asm_idx;

    // Handshakes: a beat transfers on a rising edge where valid && ready; a valid
    // output beat holds data/last until taken, and s_axis_tready never looks at tvalid.
    always_comb begin
        load          = !m_axis_tvalid || m_axis_tready;
        s_axis_tready = (state == ST_DATA) && load;
        in_hs         = s_axis_tready && s_axis_tvalid;
        last_bit      = (cnt == BLK_LAST);
        asm_idx       = 5'd31 - cnt[4:0];
        // lfsr[0] is a[n], lfsr[7] is a[n+7]; fb is a[n+8]
        fb            = lfsr[7] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0];

        state_d  = state;
        cnt_d    = cnt;
        lfsr_d   = lfsr;
        tdata_d  = m_axis_tdata;
        tvalid_d = m_axis_tvalid;
        tlast_d  = m_axis_tlast;
        ferr_d   = frame_err;

        case (state)
            ST_ASM: begin
                if (load) begin
                    tdata_d  = ASM[asm_idx];
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    if (cnt == ASM_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (in_hs) begin
                    tdata_d  = s_axis_tdata ^ (RAND_EN & lfsr[0]);
                    tvalid_d = 1'b1;
                    tlast_d  = last_bit;
                    if (s_axis_tlast != last_bit) ferr_d = 1'b1;
                    if (last_bit) begin
                        cnt_d   = '0;
                        lfsr_d  = 8'hFF;
                        state_d = ST_ASM;
                    end else begin
                        cnt_d  = cnt + 1'b1;
                        lfsr_d = {fb, lfsr[7:1]};
                    end
                end else if (load) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end
            end
            default: state_d = ST_ASM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_ASM;
            cnt           <= '0;
            lfsr          <= 8'hFF;
            m_axis_tdata  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            lfsr          <= lfsr_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tlast  <= tlast_d;
            frame_err     <= ferr_d;
        end
    end
endmodule

// File: doc/ccsds_asm_randomizer_s.md
Name: ccsds_asm_randomizer_s

Overview:
- Serial CCSDS channel-access stage placed directly downstream of the serial (8160,7136) LDPC encoder.
- Consumes the 1-bit encoder output stream, 8160 bits per codeblock, and prepends the 32-bit Attached Sync Marker (ASM) to every codeblock.
- XORs each codeblock bit with the CCSDS pseudo-randomizer sequence. The ASM is never randomized.
- Emits a 1-bit AXI-stream Channel Access Data Unit (CADU) toward the modulator/framer.

Parameters:
- ASM, 32'h1ACFFC1D, sync marker; sent MSB first.
- ASM_LEN, 32, number of ASM bits sent (ASM[31] down to ASM[32-ASM_LEN]); legal range 1..32.
- BLOCK_LEN, 8160, codeblock length in bits.
- RAND_EN, 1, 1 = apply randomizer; 0 = codeblock bits pass through unchanged.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- s_axis_tdata  input  1  codeblock bit from encoder
- s_axis_tvalid  input  1  input bit valid
- s_axis_tready  output  1  stage accepts input bit
- s_axis_tlast  input  1  encoder end-of-codeblock marker
- m_axis_tdata  output  1  CADU bit
- m_axis_tvalid  output  1  output bit valid
- m_axis_tlast  output  1  high on last codeblock bit of each CADU
- m_axis_tready  input  1  downstream accepts bit
- frame_err  output  1  sticky: s_axis_tlast misaligned with BLOCK_LEN count

Behaviour:
- Reset: all logic is synchronous to clk, reset is active-high. On a rst-high clock edge:
  - s_axis_tready=0, m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, frame_err=0
  - bit counter=0, LFSR=8'hFF, state=ASM
  - rst mid-frame aborts the CADU; the next CADU starts with a fresh ASM.
- Output register: m_axis_* are registered.
  - A new output bit is loaded when the output register is empty or being consumed: load = !m_axis_tvalid || m_axis_tready.
  - While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
- State ASM:
  - On each load, emit ASM bit [31-cnt] with tlast=0.
  - s_axis_tready=0.
  - After ASM_LEN loads: cnt=0, go to DATA.
- State DATA:
  - s_axis_tready = load, combinational from the output-register state; tready must not depend on s_axis_tvalid.
  - On an input handshake: m_axis_tdata = s_axis_tdata XOR (RAND_EN ? lfsr_out : 0); m_axis_tvalid=1; LFSR advances; cnt increments.
  - If load is true but no input handshake occurs, m_axis_tvalid goes 0.
  - On the handshake with cnt==BLOCK_LEN-1: m_axis_tlast=1, cnt=0, LFSR reloads to 8'hFF, go to ASM.
- Latency and throughput:
  - Input bit to output is 1 cycle.
  - Full throughput: 1 bit/cycle with m_axis_tready held high.
  - A CADU occupies exactly ASM_LEN+BLOCK_LEN output beats. Back-to-back CADUs have no idle beats when input is available.
- Randomizer:
  - Polynomial h(x)=x^8+x^7+x^5+x^3+1; all-ones seed at the start of every codeblock.
  - Sequence starts 0xFF,0x48,0x0E,0xC0,0x9A,0x0D,0x70,0xBC (MSB first), period 255.
  - Recurrence: a[n+8]=a[n+7]^a[n+5]^a[n+3]^a[n]. The first codeblock bit is XORed with a[0].
- Framing check: this stage is delimited by its own counter, never by s_axis_tlast.
  - frame_err is set when s_axis_tlast=1 on a handshake with cnt!=BLOCK_LEN-1.
  - frame_err is also set when s_axis_tlast=0 on a handshake with cnt==BLOCK_LEN-1.
  - Once set, frame_err stays high until rst.
- Simultaneous events:
  - The last-ASM-bit load and the first DATA handshake never occur in the same cycle; s_axis_tready rises in the cycle after the final ASM load.
  - rst has priority over any handshake.

Test Plan:
- Reset: hold rst 3 cycles with s_axis_tvalid=1 -> all outputs 0 while rst=1. First CADU bits out are 0001 1010 1100 1111 1111 1100 0001 1101 (0x1ACFFC1D).
- All-zero codeblock, m_axis_tready=1:
  - Output after ASM begins 0xFF,0x48,0x0E,0xC0,0x9A.
  - Total 8192 beats; m_axis_tlast high on beat 8192 only.
  - No idle cycles after the first valid beat.
- Two back-to-back all-zero blocks -> second CADU repeats the identical 8192-bit pattern (ASM resent, LFSR reseeded); frame_err=0.
- Random m_axis_tready (50%) with random s_axis_tvalid gaps, random data:
  - Scoreboard matches a reference model bit-exact.
  - tdata/tlast stable while stalled; no bits lost or duplicated.
- RAND_EN=0 with alternating 1010… input -> codeblock bits out equal input exactly, after the ASM.
- s_axis_tlast asserted at bit 100 of block 1 -> frame_err=1 from the next cycle, held through block 2. Output framing still at 8160-bit boundaries.
- rst pulse at data bit 4000:
  - Next output is a fresh ASM, then the randomizer restarts at 0xFF.
  - frame_err cleared.
